icache_direct: RTL and testbench



---
 rtl/icache_direct.sv | 114 +++++++++++
 tb/tb_icache_direct.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: one word per frame, single-word
// miss fill from the memory controller, saturating hit/miss counters.
module icache_direct #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX_W-1:0] req_idx_c;
    logic [TAG_W-1:0] req_tag_c;
    logic [IDX_W-1:0] fill_idx_c;
    logic [TAG_W-1:0] fill_tag_c;
    logic             lookup_hit_c;
    logic             fill_c;

    assign req_idx_c  = imemaddr[IDX_W+1:2];
    assign req_tag_c  = imemaddr[31:IDX_W+2];
    assign fill_idx_c = miss_addr_q[IDX_W+1:2];
    assign fill_tag_c = miss_addr_q[31:IDX_W+2];

    assign lookup_hit_c = imemREN && valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Next-state, fetch/memory outputs and counter updates; everything quiet while RST is high.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        ihit        = 1'b0;
        imemload    = 32'd0;
        iREN        = 1'b0;
        iaddr       = 32'd0;
        fill_c      = 1'b0;
        if (!RST) begin
            case (state_q)
                ST_IDLE: begin
                    if (imemREN) begin
                        if (lookup_hit_c) begin
                            ihit     = 1'b1;
                            imemload = data_q[req_idx_c];
                            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                        end else begin
                            state_d     = ST_FILL;
                            miss_addr_d = {imemaddr[31:2], 2'b00};
                            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                        end
                    end
                end
                ST_FILL: begin
                    iREN  = 1'b1;
                    iaddr = miss_addr_q;
                    if (!iwait) begin
                        fill_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state, counters and valid bits with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= 32'd0;
            hit_cnt_q   <= 32'd0;
            miss_cnt_q  <= 32'd0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (fill_c) valid_q[fill_idx_c] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless until the frame's valid bit is set.
    always_ff @(posedge CLK) begin
        if (fill_c) begin
            tag_q[fill_idx_c]  <= fill_tag_c;
            data_q[fill_idx_c] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: inputs driven on the falling edge,
// outputs sampled 1 ns later, all expectations hand-computed.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    icache_direct #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
    task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                         input logic wt, input logic [31:0] ld);
        @(negedge CLK);
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;

        // Cold start: two reset cycles, outputs quiet.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_iren", 32'(iREN), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_miss", miss_count, 32'd0);
        check("cold_ihit", 32'(ihit), 32'd0);
        check("cold_iren_idle", 32'(iREN), 32'd0);
        check("cold_load", imemload, 32'd0);

        // Miss service: three wait cycles, then data.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0);
            check("fill_iren", 32'(iREN), 32'd1);
            check("fill_iaddr", iaddr, 32'h0);
            check("fill_ihit", 32'(ihit), 32'd0);
        end
        check("cold_miss_cnt", miss_count, 32'd1);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h8C01_0004);
        check("fill_done_iren", 32'(iREN), 32'd1);
        check("fill_done_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0);
        check("post_fill_ihit", 32'(ihit), 32'd1);
        check("post_fill_load", imemload, 32'h8C01_0004);
        check("post_fill_iren", 32'(iREN), 32'd0);
        check("post_fill_iaddr", iaddr, 32'd0);

        // Byte offset ignored on repeat fetch.
        drive(1'b0, 1'b1, 32'h2, 1'b1, 32'h0);
        check("hit_cnt_1", hit_count, 32'd1);
        check("offs_ihit", 32'(ihit), 32'd1);
        check("offs_load", imemload, 32'h8C01_0004);
        check("offs_iren", 32'(iREN), 32'd0);

        // Conflict eviction: 0x40 shares index 0 with 0x0.
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        check("hit_cnt_2", hit_count, 32'd2);
        check("conf_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'hDEAD_BEEF);
        check("conf_iaddr", iaddr, 32'h40);
        check("conf_miss_cnt", miss_count, 32'd2);
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        check("conf_hit", 32'(ihit), 32'd1);
        check("conf_load", imemload, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0);
        check("evict_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h8C01_0004);
        check("evict_miss_cnt", miss_count, 32'd3);
        check("evict_iaddr", iaddr, 32'h0);
        check("hit_cnt_3", hit_count, 32'd3);

        // Request drop: fill for 0x10 completes despite REN low and new address.
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        check("drop_miss_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b0, 32'h20, 1'b1, 32'h0);
        check("drop_iren", 32'(iREN), 32'd1);
        check("drop_iaddr", iaddr, 32'h10);
        drive(1'b0, 1'b0, 32'h20, 1'b0, 32'h0000_1234);
        check("drop_iaddr2", iaddr, 32'h10);
        drive(1'b0, 1'b0, 32'h10, 1'b1, 32'h0);
        check("noreq_ihit", 32'(ihit), 32'd0);
        check("noreq_load", imemload, 32'd0);
        check("drop_miss_cnt", miss_count, 32'd4);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        check("drop_hit", 32'(ihit), 32'd1);
        check("drop_load", imemload, 32'h0000_1234);

        // Reset mid-fill with a response arriving in the same cycle.
        drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        check("mid_miss_ihit", 32'(ihit), 32'd0);
        drive(1'b1, 1'b1, 32'h80, 1'b0, 32'hAAAA_0000);
        check("mid_rst_iren", 32'(iREN), 32'd0);
        check("mid_rst_iaddr", iaddr, 32'd0);
        check("mid_rst_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        check("mid_rst_hits", hit_count, 32'd0);
        check("mid_rst_miss", miss_count, 32'd0);
        check("mid_rst_idle", 32'(iREN), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0);
        check("after_rst_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_0011);
        check("after_rst_iren", 32'(iREN), 32'd1);
        check("after_rst_miss", miss_count, 32'd1);
        drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        check("discard_ihit", 32'(ihit), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0022);
        check("discard_iaddr", iaddr, 32'h80);
        drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        check("refill_hit", 32'(ihit), 32'd1);
        check("refill_load", imemload, 32'h0000_0022);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        check("final_hits", hit_count, 32'd1);
        check("final_miss", miss_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
